display_scheduler: RTL and testbench

DISPLAY_SCHEDULER -- requirements
Module: display_scheduler

---
 rtl/display_scheduler_pkg.sv | 19 +
 rtl/display_scheduler_rr_next_valid.sv | 28 ++
 rtl/display_scheduler.sv | 205 ++++++++++++++++++++
 tb/tb_display_scheduler.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/display_scheduler_pkg.sv
// Shared definitions for the display scheduler: FSM state encoding,
// display value width and the largest value a 3-digit display can show.
package display_scheduler_pkg;

  localparam int VAL_W = 12;
  localparam logic [VAL_W-1:0] VAL_MAX = 12'd999;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_SHOW     = 2'd1,
    ST_OVERRIDE = 2'd2
  } state_e;

  // Clamp a raw source value to what three decimal digits can display.
  function automatic logic [VAL_W-1:0] sat_val(input logic [VAL_W-1:0] v);
    return (v > VAL_MAX) ? VAL_MAX : v;
  endfunction

endpackage

// File: rtl/display_scheduler_rr_next_valid.sv
// Round-robin search: returns the first set bit of the valid mask strictly
// after index cur, wrapping N-1 to 0 and finally reaching cur itself.
// If no bit is set, nxt falls back to cur and any is low.
module rr_next_valid #(
  parameter int N = 4
) (
  input  logic [N-1:0] valid,
  input  logic [2:0]   cur,
  output logic [2:0]   nxt,
  output logic         any
);

  logic [7:0] valid_ext;
  logic [2:0] idx;

  // Walk candidates from farthest to nearest so the nearest hit wins.
  always_comb begin
    valid_ext = 8'(valid);
    idx       = '0;
    nxt       = cur;
    for (int k = N; k >= 1; k--) begin
      idx = 3'((int'(cur) + k) % N);
      if (valid_ext[idx]) nxt = idx;
    end
    any = |valid;
  end

endmodule

// File: rtl/display_scheduler.sv
// Display scheduler: rotates through valid value sources, dwelling on each
// for DWELL_CYCLES, with an urgent override that pins source 0 for
// OVR_CYCLES. valor is registered and saturated to 999.
// Optional build macro DISPLAY_BLINK_EN: blink the display (blank output)
// with half-period BLINK_CYCLES while the override is active.
module display_scheduler
  import display_scheduler_pkg::*;
#(
  parameter int N_SRC        = 4,
  parameter int DWELL_CYCLES = 50_000_000,
  parameter int OVR_CYCLES   = 100_000_000,
  parameter int BLINK_CYCLES = 12_500_000
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_SRC-1:0]       src_valid,
  input  logic [N_SRC*VAL_W-1:0] src_value,
  input  logic                   urgent,
  output logic [VAL_W-1:0]       valor,
  output logic                   valor_valid,
  output logic [2:0]             sel_id,
  output logic                   blank
);

  localparam int DW_W = $clog2(DWELL_CYCLES + 1);
  localparam int OV_W = $clog2(OVR_CYCLES + 1);
  localparam logic [2:0] LAST_IDX = 3'(N_SRC - 1);

  state_e           state_q, state_d;
  logic [2:0]       sel_q, sel_d;
  logic [2:0]       saved_q, saved_d;
  logic [2:0]       ptr_q, ptr_d;
  logic [DW_W-1:0]  dwell_q, dwell_d;
  logic [OV_W-1:0]  ovr_q, ovr_d;
  logic [VAL_W-1:0] valor_q, valor_d;
  logic             valor_valid_q, valor_valid_d;

  logic [7:0]       valid_ext;
  logic [VAL_W-1:0] vals [8];
  logic [2:0]       rr_cur, rr_nxt;
  logic             rr_any;
  logic             urgent_ok;

  // Successor index in the rotation, wrapping at N_SRC-1.
  function automatic logic [2:0] inc_idx(input logic [2:0] x);
    return (x == LAST_IDX) ? 3'd0 : x + 3'd1;
  endfunction

  // Unpack source values into an 8-entry table so a 3-bit index is in range.
  always_comb begin
    valid_ext = 8'(src_valid);
    for (int i = 0; i < 8; i++) vals[i] = '0;
    for (int i = 0; i < N_SRC; i++) vals[i] = src_value[VAL_W*i +: VAL_W];
  end

  // Search origin: from IDLE start at the rotation pointer itself (so search
  // after the entry before it); in OVERRIDE resume after the saved source.
  always_comb begin
    rr_cur = sel_q;
    if (state_q == ST_IDLE)          rr_cur = (ptr_q == 3'd0) ? LAST_IDX : ptr_q - 3'd1;
    else if (state_q == ST_OVERRIDE) rr_cur = saved_q;
  end

  rr_next_valid #(.N(N_SRC)) u_rr (
    .valid (src_valid),
    .cur   (rr_cur),
    .nxt   (rr_nxt),
    .any   (rr_any)
  );

  assign urgent_ok = urgent && valid_ext[0];

  // Next-state logic; urgent is checked first so it beats dwell expiry.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    saved_d = saved_q;
    ptr_d   = ptr_q;
    dwell_d = dwell_q;
    ovr_d   = ovr_q;
    unique case (state_q)
      ST_IDLE: begin
        if (urgent_ok) begin
          state_d = ST_OVERRIDE;
          saved_d = sel_q;
          sel_d   = 3'd0;
          ovr_d   = '0;
        end else if (rr_any) begin
          state_d = ST_SHOW;
          sel_d   = rr_nxt;
          dwell_d = '0;
        end
      end
      ST_SHOW: begin
        if (urgent_ok) begin
          state_d = ST_OVERRIDE;
          saved_d = sel_q;
          sel_d   = 3'd0;
          ovr_d   = '0;
        end else if (!rr_any) begin
          state_d = ST_IDLE;
          ptr_d   = inc_idx(sel_q);
          dwell_d = '0;
        end else if (!valid_ext[sel_q] || dwell_q == DW_W'(DWELL_CYCLES - 1)) begin
          // Lone valid source: rr_nxt wraps back to sel_q, so it is kept.
          sel_d   = rr_nxt;
          dwell_d = '0;
        end else begin
          dwell_d = dwell_q + 1'b1;
        end
      end
      ST_OVERRIDE: begin
        if (urgent_ok) begin
          ovr_d = '0;
        end else if (!valid_ext[0] || ovr_q == OV_W'(OVR_CYCLES - 1)) begin
          dwell_d = '0;
          if (valid_ext[saved_q]) begin
            state_d = ST_SHOW;
            sel_d   = saved_q;
          end else if (rr_any) begin
            state_d = ST_SHOW;
            sel_d   = rr_nxt;
          end else begin
            state_d = ST_IDLE;
            ptr_d   = inc_idx(saved_q);
          end
        end else begin
          ovr_d = ovr_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output value follows the currently selected source one cycle later.
  always_comb begin
    valor_valid_d = (state_q != ST_IDLE);
    valor_d       = valor_valid_d ? sat_val(vals[sel_q]) : '0;
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      sel_q         <= '0;
      saved_q       <= '0;
      ptr_q         <= '0;
      dwell_q       <= '0;
      ovr_q         <= '0;
      valor_q       <= '0;
      valor_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      sel_q         <= sel_d;
      saved_q       <= saved_d;
      ptr_q         <= ptr_d;
      dwell_q       <= dwell_d;
      ovr_q         <= ovr_d;
      valor_q       <= valor_d;
      valor_valid_q <= valor_valid_d;
    end
  end

  assign valor       = valor_q;
  assign valor_valid = valor_valid_q;
  assign sel_id      = sel_q;

`ifdef DISPLAY_BLINK_EN
  localparam int BL_W = $clog2(BLINK_CYCLES + 1);

  logic [BL_W-1:0] blink_q, blink_d;
  logic            blank_q, blank_d;

  // Blink phase restarts on override entry; an urgent re-trigger only
  // extends the override and leaves the blink phase running.
  always_comb begin
    blink_d = '0;
    blank_d = 1'b0;
    if (state_d == ST_OVERRIDE && state_q == ST_OVERRIDE) begin
      if (blink_q == BL_W'(BLINK_CYCLES - 1)) begin
        blank_d = ~blank_q;
      end else begin
        blink_d = blink_q + 1'b1;
        blank_d = blank_q;
      end
    end
  end

  // Blink registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blink_q <= '0;
      blank_q <= 1'b0;
    end else begin
      blink_q <= blink_d;
      blank_q <= blank_d;
    end
  end

  assign blank = blank_q;
`else
  assign blank = 1'b0;
`endif

endmodule

// File: tb/tb_display_scheduler.sv
// Directed bench for display_scheduler with N_SRC=4, DWELL=4, OVR=6, BLINK=2.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_display_scheduler;

  localparam int N_SRC = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  src_valid;
  logic [47:0] src_value;
  logic        urgent;
  logic [11:0] valor;
  logic        valor_valid;
  logic [2:0]  sel_id;
  logic        blank;

  int n_checks = 0;
  int n_fail   = 0;

  logic [11:0] exp_q[$];

  display_scheduler #(
    .N_SRC        (N_SRC),
    .DWELL_CYCLES (4),
    .OVR_CYCLES   (6),
    .BLINK_CYCLES (2)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .src_valid   (src_valid),
    .src_value   (src_value),
    .urgent      (urgent),
    .valor       (valor),
    .valor_valid (valor_valid),
    .sel_id      (sel_id),
    .blank       (blank)
  );

  // Clock: 10 time-unit period.
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_val(input int i, input logic [11:0] v);
    src_value[12*i +: 12] = v;
  endtask

  int seq [4]        = '{0, 1, 3, 0};
  int vtab [4]       = '{10, 20, 30, 40};
`ifdef DISPLAY_BLINK_EN
  int blink_exp [6]  = '{0, 0, 1, 1, 0, 0};
`else
  int blink_exp [6]  = '{0, 0, 0, 0, 0, 0};
`endif

  initial begin
    // Reset block
    rst_n     = 1'b0;
    src_valid = '0;
    src_value = '0;
    urgent    = 1'b0;
    tick(2);
    check_eq("rst_valor", 32'(valor), 0);
    check_eq("rst_valid", 32'(valor_valid), 0);
    check_eq("rst_sel", 32'(sel_id), 0);
    check_eq("rst_blank", 32'(blank), 0);
    rst_n = 1'b1;
    tick(3);
    check_eq("idle_valor", 32'(valor), 0);
    check_eq("idle_valid", 32'(valor_valid), 0);
    check_eq("idle_sel", 32'(sel_id), 0);

    // Rotation over sources 0,1,3 with 4-cycle dwell
    set_val(0, 12'd10);
    set_val(1, 12'd20);
    set_val(2, 12'd30);
    set_val(3, 12'd40);
    src_valid = 4'b1011;
    exp_q.push_back(12'd0);
    for (int k = 2; k <= 16; k++) exp_q.push_back(12'(vtab[seq[(k-2)/4]]));
    for (int k = 1; k <= 16; k++) begin
      tick(1);
      check_eq("rot_sel", 32'(sel_id), 32'(seq[(k-1)/4]));
      check_eq("rot_valor", 32'(valor), 32'(exp_q.pop_front()));
    end
    check_eq("rot_valid", 32'(valor_valid), 1);

    // Drop the shown source: advance without waiting for dwell
    tick(1);
    check_eq("drop_pre_sel", 32'(sel_id), 1);
    src_valid = 4'b1001;
    tick(1);
    check_eq("drop_adv_sel", 32'(sel_id), 3);
    tick(3);
    check_eq("drop_hold_sel", 32'(sel_id), 3);
    tick(1);
    check_eq("drop_next_sel", 32'(sel_id), 0);
    tick(4);
    check_eq("pre_urg_sel", 32'(sel_id), 3);

    // Urgent override while showing source 3
    urgent = 1'b1;
    tick(1);
    urgent = 1'b0;
    for (int i = 0; i < 6; i++) begin
      check_eq("ovr_sel", 32'(sel_id), 0);
      check_eq("ovr_blank", 32'(blank), 32'(blink_exp[i]));
      tick(1);
    end
    check_eq("ovr_ret_sel", 32'(sel_id), 3);
    check_eq("ovr_ret_blank", 32'(blank), 0);
    check_eq("ovr_ret_valor", 32'(valor), 10);

    // Saturation, then asynchronous reset mid-override
    set_val(0, 12'd1500);
    urgent = 1'b1;
    tick(1);
    urgent = 1'b0;
    check_eq("sat_sel", 32'(sel_id), 0);
    tick(1);
    check_eq("sat_valor", 32'(valor), 999);
    check_eq("sat_valid", 32'(valor_valid), 1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("arst_valor", 32'(valor), 0);
    check_eq("arst_valid", 32'(valor_valid), 0);
    check_eq("arst_sel", 32'(sel_id), 0);
    check_eq("arst_blank", 32'(blank), 0);

    // After reset: urgent ignored without source 0; lone source kept
    tick(1);
    rst_n     = 1'b1;
    src_valid = 4'b0100;
    set_val(2, 12'd30);
    urgent    = 1'b1;
    tick(1);
    urgent = 1'b0;
    check_eq("ign_urg_sel", 32'(sel_id), 2);
    tick(1);
    check_eq("lone_valor", 32'(valor), 30);
    tick(6);
    check_eq("lone_keep_sel", 32'(sel_id), 2);
    check_eq("lone_blank", 32'(blank), 0);

    // All sources gone: back to IDLE
    src_valid = 4'b0000;
    tick(2);
    check_eq("end_idle_valid", 32'(valor_valid), 0);
    check_eq("end_idle_valor", 32'(valor), 0);

    // Report
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
